// File: rtl/pulse_train_gen_pkg.sv
// rtl/pulse_train_gen_pkg.sv - shared state encoding and default widths for the pulse train generator
package pulse_train_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int GAP_W_DEF = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ARM   = 3'd1;
    localparam state_t ST_PULSE = 3'd2;
    localparam state_t ST_GAP   = 3'd3;
    localparam state_t ST_TAIL  = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/pulse_train_gen_gap_timer.sv
// rtl/pulse_train_gen_gap_timer.sv - loadable down-counter timing the idle gap between pulses
module pulse_gap_timer
    import pulse_train_pkg::*;
#(
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [GAP_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             last_o
);

    logic [GAP_W-1:0] cnt_q;
    logic [GAP_W-1:0] cnt_d;

    // Load takes priority; otherwise count down while enabled, parking at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The counter reaches zero at the coming edge, so this is the final gap cycle.
    assign last_o = (cnt_q == GAP_W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - command-driven burst of N single-cycle pulses framed by start_o
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [GAP_W-1:0] cmd_gap,
    input  logic             abort,
    output logic             start_o,
    output logic             din_o,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] sent_cnt
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [GAP_W-1:0] g_q, g_d;
    logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
    logic             cmd_ready_q, start_q, din_q, busy_q, done_q, aborted_q;

    logic accept;
    logic in_burst;
    logic abort_hit;
    logic gap_last;

    assign accept    = cmd_valid && cmd_ready_q;
    assign in_burst  = (state_q == ST_ARM) || (state_q == ST_PULSE) ||
                       (state_q == ST_GAP) || (state_q == ST_TAIL);
    assign abort_hit = abort && in_burst;

    pulse_gap_timer #(
        .GAP_W (GAP_W)
    ) u_gap_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     ((state_q == ST_PULSE) && (state_d == ST_GAP)),
        .load_val_i (g_q),
        .en_i       (state_q == ST_GAP),
        .last_o     (gap_last)
    );

    // Next-state logic; abort wins over every burst-state transition.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        g_d     = g_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    n_d     = cmd_count;
                    g_d     = cmd_gap;
                    state_d = (cmd_count == '0) ? ST_DONE : ST_ARM;
                end
            end
            ST_ARM:   state_d = ST_PULSE;
            ST_PULSE: begin
                // sent_cnt_q already includes the pulse on the wire this cycle.
                if (sent_cnt_q == n_q) begin
                    state_d = ST_TAIL;
                end else if (g_q == '0) begin
                    state_d = ST_PULSE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP:   state_d = gap_last ? ST_PULSE : ST_GAP;
            ST_TAIL:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_hit) begin
            state_d = ST_IDLE;
        end
    end

    // Pulse count advances together with din_o so an aborted pulse is still counted.
    always_comb begin
        sent_cnt_d = sent_cnt_q;
        if (accept) begin
            sent_cnt_d = '0;
        end else if (state_d == ST_PULSE) begin
            sent_cnt_d = sent_cnt_q + 1'b1;
        end
    end

    // State, command and output registers; outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            g_q         <= '0;
            sent_cnt_q  <= '0;
            cmd_ready_q <= 1'b1;
            start_q     <= 1'b0;
            din_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            g_q         <= g_d;
            sent_cnt_q  <= sent_cnt_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            start_q     <= (state_d == ST_ARM) || (state_d == ST_PULSE) ||
                           (state_d == ST_GAP) || (state_d == ST_TAIL);
            din_q       <= (state_d == ST_PULSE);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
            aborted_q   <= abort_hit;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign start_o   = start_q;
    assign din_o     = din_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign sent_cnt  = sent_cnt_q;

endmodule
